// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle control FSM.
// The TRAP state exists only when MC_CTRL_TRAP_EN is defined.
package mc_ctrl_pkg;
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MC_CTRL_TRAP_EN
    , S_TRAP = 3'd5
`endif
  } state_e;

  typedef struct packed {
    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_bne;
    logic is_illegal;
  } op_class_t;
endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode classifier shared by the EXEC, MEM and WB decode.
module mc_op_class
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  cls
);
  always_comb begin
    cls            = '0;
    cls.is_rtype   = (opcode == OP_AND) || (opcode == OP_OR) || (opcode == OP_ADD) ||
                     (opcode == OP_SUB) || (opcode == OP_SLT);
    cls.is_lw      = (opcode == OP_LW);
    cls.is_sw      = (opcode == OP_SW);
    cls.is_bne     = (opcode == OP_BNE);
    cls.is_illegal = !(cls.is_rtype || cls.is_lw || cls.is_sw || cls.is_bne);
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the shared-ALU MIPS-style datapath.
// Define MC_CTRL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ST_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  input  logic             alu_eq,
  output logic [3:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             ab_we,
  output logic             aluout_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [CNT_W-1:0] instret,
  output logic [ST_W-1:0]  state_o,
  output logic             trap
);
  state_e    state, nxt;
  op_class_t cls;
  logic      retire;

  mc_op_class u_cls (.opcode(opcode), .cls(cls));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    nxt        = state;
    retire     = 1'b0;
    alu_op     = 4'h0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    iord       = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    ab_we      = 1'b0;
    aluout_we  = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (state)
      S_FETCH: if (run) begin
        mem_re    = 1'b1;
        alu_src_b = SRCB_ONE;
        alu_op    = OP_ADD;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form PC+sext(imm) in ALUOut for a possible BNE.
        ab_we     = 1'b1;
        aluout_we = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = OP_ADD;
`ifdef MC_CTRL_TRAP_EN
        nxt = cls.is_illegal ? S_TRAP : S_EXEC;
`else
        nxt = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (cls.is_rtype) begin
          alu_op    = opcode;
          alu_src_a = 1'b1;
          aluout_we = 1'b1;
          nxt       = S_WB;
        end else if (cls.is_lw || cls.is_sw) begin
          alu_op    = opcode;
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          aluout_we = 1'b1;
          nxt       = S_MEM;
        end else if (cls.is_bne) begin
          alu_op    = OP_SUB;
          alu_src_a = 1'b1;
          pc_we     = !alu_eq;
          pc_src    = !alu_eq;
          nxt       = S_FETCH;
          retire    = 1'b1;
        end else begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (cls.is_lw) begin
          mem_re = 1'b1;
          if (mem_ready) begin
            mdr_we = 1'b1;
            nxt    = S_WB;
          end
        end else if (cls.is_sw) begin
          mem_we = 1'b1;
          if (mem_ready) begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
        end else begin
          nxt = S_FETCH;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = cls.is_rtype;
        mem_to_reg = cls.is_lw;
        nxt        = S_FETCH;
        retire     = 1'b1;
      end
`ifdef MC_CTRL_TRAP_EN
      S_TRAP: nxt = S_TRAP;
`endif
      default: nxt = S_FETCH;
    endcase

    // Reset abandons any access in flight, including a write seen this cycle.
    if (rst) begin
      nxt        = S_FETCH;
      retire     = 1'b0;
      alu_op     = 4'h0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      iord       = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      ab_we      = 1'b0;
      aluout_we  = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  assign state_o = ST_W'(state);

`ifdef MC_CTRL_TRAP_EN
  assign trap = (state == S_TRAP) && !rst;
`else
  assign trap = 1'b0;
`endif
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control FSM that sequences the shared 16-bit ALU, register file and unified memory of the MIPS-style datapath.
- Emits per-state strobes and ALU opcode/operand selects.
- Waits on memory handshake, resolves BNE from the ALU eq flag, counts retired instructions.
- Sits between the instruction register and the datapath muxes.

Parameters:
CNT_W, 16, width of retired-instruction counter instret.
ST_W, 3, width of state encoding (state_o).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  permits leaving FETCH; low = hold in FETCH, idle
opcode  in  4  IR[15:12] from instruction register
mem_ready  in  1  memory completes current read/write this cycle
alu_eq  in  1  ALU eq flag (X==Y)
alu_op  out  4  opcode driven to ALU opcod
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  0=reg B, 1=const 1, 2=sext(IR[3:0])
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
ir_we  out  1  load instruction register
mdr_we  out  1  load memory data register
ab_we  out  1  load A/B operand registers
aluout_we  out  1  load ALUOut register
pc_we  out  1  load PC
pc_src  out  1  0=ALU result, 1=ALUOut
reg_we  out  1  register-file write
reg_dst  out  1  0=rt IR[7:4], 1=rd IR[3:0]
mem_to_reg  out  1  0=ALUOut, 1=MDR
instret  out  CNT_W  retired instruction count
state_o  out  ST_W  current state for debug
trap  out  1  illegal opcode flag (feature only; else tied 0)

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Only the state and instret are registered. Strobes are decoded combinationally from state, opcode and mem_ready. Non-listed strobes are 0.
- Reset: state=FETCH and instret=0 on the edge. While rst=1, every strobe and reg_we/mem_we/pc_we are forced 0. alu_op=0 during reset.
- FETCH:
  - If run=0: all strobes 0, stay in FETCH.
  - Else: mem_re=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0x2.
  - On mem_ready=1: ir_we=1, pc_we=1, pc_src=0, go to DECODE. Otherwise hold with no writes.
- DECODE:
  - ab_we=1, aluout_we=1, alu_src_a=0, alu_src_b=2, alu_op=0x2. This computes the branch target into ALUOut.
  - Go to EXEC. Unknown opcode goes to EXEC without the feature.
- EXEC, by opcode:
  - R-class {0x0,0x1,0x2,0x6,0x7}: alu_op=opcode, src_a=1, src_b=0, aluout_we=1, go to WB.
  - 0x8/0xA: alu_op=opcode, src_a=1, src_b=2, aluout_we=1, go to MEM.
  - 0xE: alu_op=0x6, src_a=1, src_b=0. If alu_eq=0: pc_we=1, pc_src=1. Go to FETCH and retire.
  - Other opcodes: no strobes, go to FETCH and retire (NOP).
- MEM:
  - iord=1.
  - LW: mem_re=1. On mem_ready: mdr_we=1, go to WB.
  - SW: mem_we=1. On mem_ready: go to FETCH and retire.
  - mem_ready=0 holds MEM with the strobes steady.
- WB: reg_we=1, reg_dst=1 for R-class and 0 for LW, mem_to_reg=1 for LW. Go to FETCH and retire.
- Retire: instret increments by 1 on the edge leaving the final state. It wraps 2^CNT_W-1 → 0 silently.
- Cycle counts with mem_ready always 1: R-class 4, LW 5, SW 4, BNE 3, NOP 3.
- Opcode is sampled every cycle and must be stable after the ir_we edge. The FSM uses live IR.
- rst mid-access abandons the access: next state is FETCH and mem_we drops in the same cycle rst is seen. instret is cleared.
- run deasserted outside FETCH is ignored. The current instruction completes, then the FSM idles in FETCH.

Optional Feature:
Macro MC_CTRL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP instead of EXEC.
  - TRAP: trap=1, all strobes 0, instret frozen.
  - TRAP is left only by rst.
- Undefined:
  - The TRAP state is not generated and trap is tied 0.
  - Unknown opcodes execute as NOP.

Decomposition:
- Package mc_ctrl_pkg holds:
  - Opcode constants: OP_AND=0x0, OP_OR=0x1, OP_ADD=0x2, OP_SUB=0x6, OP_SLT=0x7, OP_LW=0x8, OP_SW=0xA, OP_BNE=0xE.
  - State enum.
  - alu_src_b encodings SRCB_REG/SRCB_ONE/SRCB_IMM.
- One sub-module, mc_op_class: combinational opcode → {is_rtype, is_lw, is_sw, is_bne, is_illegal}. It is used by EXEC, MEM and WB decode.

Test Plan:
1. Reset held 3 cycles with run=1 → all strobes 0, state_o=0, instret=0. First cycle after release: mem_re=1, alu_op=0x2, alu_src_b=1.
2. opcode=0x6 (SUB), mem_ready=1 → state sequence 0,1,2,4,0. EXEC alu_op=0x6, WB reg_we=1, reg_dst=1. instret 0→1.
3. opcode=0x8 (LW), mem_ready low for 2 cycles in MEM → MEM held 3 cycles with mem_re=1, iord=1. mdr_we only on the ready cycle. WB mem_to_reg=1, reg_dst=0. Total 7 cycles.
4. opcode=0xE: alu_eq=0 → EXEC pc_we=1, pc_src=1. alu_eq=1 → pc_we=0 in EXEC. Both return to FETCH after 3 cycles.
5. SW with rst asserted on the first MEM cycle → mem_we=0 that cycle, next state FETCH, instret=0.
6. opcode=0x3: without MC_CTRL_TRAP_EN → NOP, retire in 3 cycles. With the macro → state TRAP, trap=1 held for 10 cycles, instret unchanged until rst.
